data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/mem_pkg.sv | 28 ++
 rtl/wait_counter.sv | 35 +++
 rtl/data_mem_responder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the data memory responder.
//   - state_t      : responder FSM states (IDLE / WAIT / RESP)
//   - *_DEF        : default values for the responder parameters
//   - CNT_W        : width of the wait-state countdown
//   - word_off()   : byte address -> word offset relative to a base
package mem_pkg;

  localparam int          WAIT_CYCLES_DEF = 2;
  localparam int          DEPTH_LOG2_DEF  = 8;
  localparam logic [31:0] BASE_ADDR_DEF   = 32'h1000_0000;

  // Holds WAIT_CYCLES up to 15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Word offset of a byte address from base. The result is only meaningful
  // when addr >= base; callers qualify it with their own range check.
  function automatic logic [31:0] word_off(input logic [31:0] addr,
                                           input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/wait_counter.sv
// wait_counter: wait-state countdown for the memory responder.
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous active-low reset, clears the count
//   load     - load load_val (has priority over dec)
//   load_val - initial countdown value
//   dec      - decrement by one; ignored when the count is already 0
//   done     - count == 1, i.e. the current cycle is the last wait state
module wait_counter
  import mem_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      // Saturates at 0 rather than wrapping.
      count <= count - 1'b1;
    end
  end

  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding word memory behind a valid/ready
// request channel and a valid/ready response channel, with a fixed number
// of wait states per access.
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset (storage is not cleared)
//   req_valid  - request present
//   req_ready  - responder idle and able to accept
//   req_write  - 1 = store, 0 = load
//   req_addr   - byte address
//   req_wdata  - store data
//   resp_valid - response present
//   resp_ready - initiator consumes the response
//   resp_rdata - load data; 0 for stores and for errored accesses
//   resp_err   - access was misaligned or outside the storage window
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int          WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int          DEPTH_LOG2  = DEPTH_LOG2_DEF,
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);

  // Storage: flat register array, deliberately outside the reset domain.
  logic [31:0] mem [DEPTH];

  state_t state, nxt;

  logic                  accept;
  logic                  cnt_done;
  logic                  enter_resp;

  // Decode of the request currently on the input port.
  logic [31:0]           woff_in;
  logic                  err_in;
  logic [DEPTH_LOG2-1:0] idx_in;

  // Access captured at acceptance.
  logic                  lat_write;
  logic                  lat_err;
  logic [DEPTH_LOG2-1:0] lat_idx;
  logic [31:0]           lat_wdata;

  // Access as seen on the edge that enters RESP.
  logic                  e_write;
  logic                  e_err;
  logic [DEPTH_LOG2-1:0] e_idx;
  logic [31:0]           e_wdata;

  assign accept = req_valid & req_ready;

  assign woff_in = word_off(req_addr, BASE_ADDR);
  assign err_in  = (req_addr[1:0] != 2'b00) ||
                   (req_addr < BASE_ADDR)   ||
                   (woff_in >= 32'(DEPTH));
  assign idx_in  = woff_in[DEPTH_LOG2-1:0];

  // With no wait states the RESP entry happens on the accepting edge, so the
  // access must come straight from the port rather than from the latches.
  always_comb begin
    e_write = lat_write;
    e_err   = lat_err;
    e_idx   = lat_idx;
    e_wdata = lat_wdata;
    if (state == IDLE) begin
      e_write = req_write;
      e_err   = err_in;
      e_idx   = idx_in;
      e_wdata = req_wdata;
    end
  end

  always_comb begin
    if (NO_WAIT) enter_resp = (state == IDLE) && accept;
    else         enter_resp = (state == WAIT) && cnt_done;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept)     nxt = NO_WAIT ? RESP : WAIT;
      WAIT:    if (cnt_done)   nxt = RESP;
      RESP:    if (resp_ready) nxt = IDLE;
      default:                 nxt = IDLE;
    endcase
  end

  wait_counter u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (accept && !NO_WAIT),
    .load_val (CNT_W'(WAIT_CYCLES)),
    .dec      (state == WAIT),
    .done     (cnt_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // req_ready is registered so it stays low through reset and rises on the
  // first edge after release; it is also low on the RESP->IDLE edge, which
  // keeps back-to-back accesses at least WAIT_CYCLES+2 cycles apart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_ready <= 1'b0;
    end else begin
      req_ready <= (nxt == IDLE);
    end
  end

  assign resp_valid = (state == RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_write <= req_write;
      lat_err   <= err_in;
      lat_idx   <= idx_in;
      lat_wdata <= req_wdata;
    end
  end

  // Read data comes from the array as it was before this edge's store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (enter_resp) begin
      resp_err   <= e_err;
      resp_rdata <= (!e_err && !e_write) ? mem[e_idx] : 32'h0;
    end
  end

  // Stores commit only on RESP entry, so an access dropped by reset in WAIT
  // never reaches the array.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && e_write && !e_err) begin
      mem[e_idx] <= e_wdata;
    end
  end

endmodule
